// File: rtl/sfifo_param_buffer.sv
// Parametrised single-clock synchronous FIFO with occupancy count,
// almost-full/empty thresholds, sticky error flags and optional FWFT read.
module sfifo_param_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_LEVEL   = (1 << ADDR_WIDTH) - 2,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                  clk,
    input  logic                  Rst,
    input  logic                  EN,
    input  logic                  WR_EN,
    input  logic                  RD_EN,
    input  logic                  CLR_ERR,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ALMOST_EMPTY,
    output logic                  ALMOST_FULL,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LP_AF    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] LP_AE    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_ovf;
    logic                  r_udf;

    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == LP_DEPTH);
    assign w_rd_ok = RD_EN & ~w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_wr_ok = WR_EN & (~w_full | w_rd_ok);

    always_ff @(posedge clk) begin
        if (Rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (EN) begin
            if (w_wr_ok)
                r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_rd_ok)
                r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + (ADDR_WIDTH+1)'(1);
                2'b01:   r_count <= r_count - (ADDR_WIDTH+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!Rst && EN && w_wr_ok)
            r_mem[r_wr_ptr] <= dataIn;
    end

    // Clear first so an error in the same cycle keeps its flag set.
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else if (EN) begin
            if (CLR_ERR) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end
            if (WR_EN && !w_wr_ok)
                r_ovf <= 1'b1;
            if (RD_EN && w_empty)
                r_udf <= 1'b1;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign dataOut = w_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] r_dout;
            always_ff @(posedge clk) begin
                if (Rst)
                    r_dout <= '0;
                else if (EN && w_rd_ok)
                    r_dout <= r_mem[r_rd_ptr];
            end
            assign dataOut = r_dout;
        end
    endgenerate

    assign COUNT        = r_count;
    assign EMPTY        = w_empty;
    assign FULL         = w_full;
    assign ALMOST_EMPTY = (r_count <= LP_AE);
    assign ALMOST_FULL  = (r_count >= LP_AF);
    assign OVERFLOW     = r_ovf;
    assign UNDERFLOW    = r_udf;

endmodule

// File: doc/sfifo_param_buffer.md
# sfifo_param_buffer

Parametrised single-clock synchronous FIFO, next generation of the team's fixed 32-bit synchronous FIFO buffer. Width and depth are parameters; the block adds an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and an optional first-word-fall-through (FWFT) read mode. It sits between a single-clock producer and consumer as a drop-in replacement, with the same clock-enable and write/read-enable handshake.

## Interface
- DATA_WIDTH, 32, data word width
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (default 8)
- AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_LEVEL
- AE_LEVEL, 2, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL
- FWFT, 0, 0 = registered read (data after pop), 1 = head word presented before pop

- clk  in  1  clock; all state updates on rising edge
- Rst  in  1  reset; synchronous, active-high
- EN  in  1  global enable; 0 freezes all state
- WR_EN  in  1  write request
- RD_EN  in  1  read (pop) request
- CLR_ERR  in  1  clears OVERFLOW/UNDERFLOW (sync)
- dataIn  in  DATA_WIDTH  write data
- dataOut  out  DATA_WIDTH  read data
- EMPTY  out  1  COUNT == 0
- FULL  out  1  COUNT == DEPTH
- ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL
- COUNT  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- OVERFLOW  out  1  sticky: write dropped
- UNDERFLOW  out  1  sticky: read rejected

## Operation
- Storage: DEPTH x DATA_WIDTH array, not reset. wr_ptr, rd_ptr are ADDR_WIDTH bits and wrap DEPTH-1 -> 0 naturally; COUNT is a separate ADDR_WIDTH+1-bit register.
- Reset (Rst=1 at edge, overrides EN): pointers 0, COUNT 0, dataOut 0, EMPTY 1, FULL 0, ALMOST_EMPTY 1, ALMOST_FULL (0 >= AF_LEVEL), OVERFLOW 0, UNDERFLOW 0. Reset mid-operation discards all contents.
- EN=0: no pointer, COUNT, memory, dataOut or error-flag change; requests ignored, not flagged.
- With EN=1, let rd_ok = RD_EN & !EMPTY; wr_ok = WR_EN & (!FULL | rd_ok).
  - wr_ok: mem[wr_ptr] <= dataIn, wr_ptr++.
  - rd_ok: rd_ptr++; FWFT=0: dataOut <= mem[rd_ptr].
  - COUNT += wr_ok - rd_ok (unchanged when both).
  - WR_EN & !wr_ok: OVERFLOW <= 1. RD_EN & EMPTY: UNDERFLOW <= 1 (even if a write is accepted the same cycle).
  - CLR_ERR: both error flags <= 0; a new error in the same cycle wins (flag set).
- FULL with simultaneous read and write: both accepted, COUNT stays DEPTH. EMPTY with simultaneous read and write: write accepted, read rejected.
- FWFT=0: dataOut holds its last value when no read is accepted.
- FWFT=1: dataOut = EMPTY ? 0 : mem[rd_ptr] (combinational from registered state); a pop advances to the next word.
- Status flags are combinational decodes of the registered COUNT.

## Timing
- Write accepted at edge N: COUNT and flags update after N; the word is readable at edge N+1 (FWFT=1: visible on dataOut after N).
- FWFT=0 read accepted at edge N: dataOut valid after N, i.e. 1-cycle latency.
- Maximum throughput is one write and one read per cycle.
- Error flags set after the offending edge and hold until Rst or CLR_ERR.

## Test plan
- Reset, then RD_EN=1 for 2 cycles on an empty FIFO -> dataOut stays 0, COUNT 0, EMPTY 1, UNDERFLOW 1. CLR_ERR pulse -> UNDERFLOW 0.
- Defaults; write AAAA0001..AAAA000A on consecutive cycles -> first 8 accepted. ALMOST_FULL after the 6th write, FULL and COUNT=8 after the 8th, 9th/10th dropped, OVERFLOW 1.
- Then RD_EN=1 for 10 cycles -> dataOut AAAA0001..AAAA0008 in order. EMPTY after the 8th pop, ALMOST_EMPTY when COUNT<=2, UNDERFLOW 1 from the 9th request, dataOut holds AAAA0008.
- Wrap-around: 20 words streamed with interleaved reads keeping COUNT 3..6 -> output order preserved across pointer wrap.
- Simultaneous: at FULL, RD_EN=WR_EN=1 -> COUNT stays 8, no OVERFLOW. At EMPTY, both=1 -> COUNT 1, UNDERFLOW 1. EN=0 with requests -> no state change.
- Reset mid-stream with COUNT=5 -> COUNT 0, EMPTY 1, dataOut 0. FWFT=1 build: write 0x11 -> dataOut=0x11 next cycle without a pop; pop -> next word or 0 if empty.
